multicycle_control_unit: RTL and testbench

//  Parametrised multi-cycle successor of the single-cycle decoder. It takes

---
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with memory timeout
module multicycle_control_unit #(
    parameter int INST_W  = 8,
    parameter int REG_AW  = 2,
    parameter int MEM_TMO = 15,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic              mem_ack,
    output logic [3:0]        opcode,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs,
    output logic              imm,
    output logic              alu_src,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              flag_we,
    output logic              busy,
    output logic              bus_err,
    output logic [CNT_W-1:0]  retired
);

    localparam int TMO_W = $clog2(MEM_TMO + 1);

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_MI  = 4'b0010;
    localparam logic [3:0] OP_MR  = 4'b0011;
    localparam logic [3:0] OP_CM  = 4'b0111;
    localparam logic [3:0] OP_ORI = 4'b1001;
    localparam logic [3:0] OP_XRI = 4'b1011;
    localparam logic [3:0] OP_SMI = 4'b1100;
    localparam logic [3:0] OP_SBI = 4'b1101;
    localparam logic [3:0] OP_ANI = 4'b1110;
    localparam logic [3:0] OP_CMI = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [INST_W-1:0] ir;
    logic [TMO_W-1:0]  wait_cnt;

    logic is_mem;
    logic is_ld;
    logic is_move;
    logic is_cmp;
    logic is_alu;
    logic is_imm;
    logic accept;
    logic timeout;
    logic retire;
    logic mem_abort;

    // Instruction fields come straight from the IR so they only move on acceptance
    assign opcode = ir[INST_W-1 -: 4];
    assign rd     = ir[INST_W-5 -: REG_AW];
    assign rs     = ir[INST_W-5-REG_AW -: REG_AW];
    assign imm    = is_imm;

    always_comb begin
        is_mem  = (opcode == OP_LD) || (opcode == OP_ST);
        is_ld   = (opcode == OP_LD);
        is_move = (opcode == OP_MI) || (opcode == OP_MR);
        is_cmp  = (opcode == OP_CM) || (opcode == OP_CMI);
        is_alu  = !is_mem && !is_move && !is_cmp;
        is_imm  = 1'b0;
        case (opcode)
            OP_MI, OP_SMI, OP_SBI, OP_ANI,
            OP_ORI, OP_XRI, OP_CMI: is_imm = 1'b1;
            default:                is_imm = 1'b0;
        endcase
    end

    assign accept    = (state == S_FETCH) && inst_valid;
    assign timeout   = (wait_cnt == TMO_W'(MEM_TMO - 1));
    assign mem_abort = (state == S_MEM) && !mem_ack && timeout;
    assign retire    = ((state == S_EXEC) && is_cmp) ||
                       ((state == S_MEM) && mem_ack && !is_ld) ||
                       (state == S_WB);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = inst_valid ? S_DECODE : S_FETCH;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                if (is_cmp) begin
                    state_nx = S_FETCH;
                end else if (is_mem) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_nx = is_ld ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_nx = S_FETCH;
                end
            end
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Enables are a pure function of state, so an async reset kills them at once
    always_comb begin
        inst_ready = 1'b0;
        busy       = 1'b1;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        flag_we    = 1'b0;
        case (state)
            S_FETCH: begin
                inst_ready = 1'b1;
                busy       = 1'b0;
            end
            S_EXEC: begin
                alu_src = is_mem;
                flag_we = is_alu || is_cmp;
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = is_ld;
                mem_write = !is_ld;
            end
            S_WB:    reg_write = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= '0;
        end else if (accept) begin
            ir <= inst;
        end
    end

    // Counts MEM cycles already spent; held at zero outside MEM so each access starts fresh
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state != S_MEM) begin
            wait_cnt <= '0;
        end else if (!timeout) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_err <= 1'b0;
        end else if (mem_abort) begin
            bus_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - table-driven scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic [7:0]       inst;
    logic             inst_valid;
    logic             inst_ready;
    logic             mem_ack;
    logic [3:0]       opcode;
    logic [1:0]       rd;
    logic [1:0]       rs;
    logic             imm;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             flag_we;
    logic             busy;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    multicycle_control_unit #(
        .INST_W(8), .REG_AW(2), .MEM_TMO(15), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .mem_ack(mem_ack), .opcode(opcode), .rd(rd),
        .rs(rs), .imm(imm), .alu_src(alu_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .flag_we(flag_we),
        .busy(busy), .bus_err(bus_err), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] inst;
        int ack_wait;   // MEM cycle index (0-based) on which ack is given, -1 = never
        int lat;        // edges from acceptance to inst_ready
        int rw_cyc;     // cycle of reg_write, 0 = none
        int fl_cyc;     // cycle of flag_we, 0 = none
        int mrd;
        int mwr;
        int alu;
        int ret;
        int berr;
        int op;
        int rdv;
        int rsv;
        int immv;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_retired;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_inst(input vec_t v);
        int cyc, memc, rdn, wrn, rwn, rwc, fln, flc, alun, ovl, lat;
        vec_t e;
        cyc = 1; memc = 0; rdn = 0; wrn = 0; rwn = 0; rwc = 0;
        fln = 0; flc = 0; alun = 0; ovl = 0; lat = -1;
        sb.push_back(v);
        inst = v.inst;
        inst_valid = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        while (cyc <= 60) begin
            if (inst_ready) begin
                lat = cyc;
                break;
            end
            if (reg_write) begin rwn++; rwc = cyc; end
            if (flag_we)   begin fln++; flc = cyc; end
            if (alu_src)   alun++;
            if (mem_read && mem_write) ovl++;
            if (mem_read)  rdn++;
            if (mem_write) wrn++;
            if (mem_read || mem_write) begin
                memc++;
                mem_ack = (v.ack_wait >= 0) && (memc - 1 == v.ack_wait);
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        e = sb.pop_front();
        exp_retired = exp_retired + CNT_W'(e.ret);
        check($sformatf("latency %02h", e.inst), lat, e.lat);
        check($sformatf("reg_write_cycle %02h", e.inst), rwc, e.rw_cyc);
        check($sformatf("reg_write_count %02h", e.inst), rwn, (e.rw_cyc != 0) ? 1 : 0);
        check($sformatf("flag_we_cycle %02h", e.inst), flc, e.fl_cyc);
        check($sformatf("flag_we_count %02h", e.inst), fln, (e.fl_cyc != 0) ? 1 : 0);
        check($sformatf("mem_read_cycles %02h", e.inst), rdn, e.mrd);
        check($sformatf("mem_write_cycles %02h", e.inst), wrn, e.mwr);
        check($sformatf("alu_src_cycles %02h", e.inst), alun, e.alu);
        check($sformatf("rd_wr_overlap %02h", e.inst), ovl, 0);
        check($sformatf("opcode %02h", e.inst), int'(opcode), e.op);
        check($sformatf("rd %02h", e.inst), int'(rd), e.rdv);
        check($sformatf("rs %02h", e.inst), int'(rs), e.rsv);
        check($sformatf("imm %02h", e.inst), int'(imm), e.immv);
        check($sformatf("bus_err %02h", e.inst), int'(bus_err), e.berr);
        check($sformatf("retired %02h", e.inst), int'(retired), int'(exp_retired));
    endtask

    initial begin
        int n;
        vecs[0]  = '{8'h46, -1, 4, 3, 2, 0, 0, 0, 1, 0, 4'h4, 1, 2, 0};
        vecs[1]  = '{8'h0C,  3, 8, 7, 0, 4, 0, 5, 1, 0, 4'h0, 3, 0, 0};
        vecs[2]  = '{8'hF5, -1, 3, 0, 2, 0, 0, 0, 1, 0, 4'hF, 1, 1, 1};
        vecs[3]  = '{8'h2B, -1, 4, 3, 0, 0, 0, 0, 1, 0, 4'h2, 2, 3, 1};
        vecs[4]  = '{8'h1E,  0, 4, 0, 0, 0, 1, 2, 1, 0, 4'h1, 3, 2, 0};
        vecs[5]  = '{8'h07,  0, 5, 4, 0, 1, 0, 2, 1, 0, 4'h0, 1, 3, 0};
        vecs[6]  = '{8'h7A, -1, 3, 0, 2, 0, 0, 0, 1, 0, 4'h7, 2, 2, 0};
        vecs[7]  = '{8'h93, -1, 4, 3, 2, 0, 0, 0, 1, 0, 4'h9, 0, 3, 1};
        vecs[8]  = '{8'h31, -1, 4, 3, 0, 0, 0, 0, 1, 0, 4'h3, 0, 1, 0};
        vecs[9]  = '{8'h10, -1, 18, 0, 0, 0, 15, 16, 0, 1, 4'h1, 0, 0, 0};
        vecs[10] = '{8'h12,  2, 6, 0, 0, 0, 3, 4, 1, 1, 4'h1, 0, 2, 0};
        vecs[11] = '{8'hA6, -1, 4, 3, 2, 0, 0, 0, 1, 1, 4'hA, 1, 2, 0};
        vecs[12] = '{8'hD9, -1, 4, 3, 2, 0, 0, 0, 1, 1, 4'hD, 2, 1, 1};

        // Reset held with a valid instruction waiting
        reset_n = 1'b0;
        inst = 8'h46;
        inst_valid = 1'b1;
        mem_ack = 1'b0;
        exp_retired = '0;
        repeat (3) @(negedge clk);
        check("reset inst_ready", int'(inst_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset enables", int'({alu_src, mem_read, mem_write, reg_write, flag_we}), 0);
        check("reset retired", int'(retired), 0);
        check("reset bus_err", int'(bus_err), 0);
        check("reset opcode", int'(opcode), 0);
        reset_n = 1'b1;
        #1;
        check("post_release enables", int'({mem_read, mem_write, reg_write, flag_we}), 0);
        @(posedge clk);
        #1;
        check("first_edge accept busy", int'(busy), 1);
        check("first_edge accept opcode", int'(opcode), 4);
        inst_valid = 1'b0;
        n = 0;
        while (!inst_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_seq return_latency", n, 4);
        exp_retired = exp_retired + CNT_W'(1);
        check("reset_seq retired", int'(retired), int'(exp_retired));

        for (int i = 0; i < 13; i++) run_inst(vecs[i]);

        // Run compares until the narrow counter wraps back through zero
        for (int i = 0; i < 16; i++) run_inst('{8'h75, -1, 3, 0, 2, 0, 0, 0, 1, 1, 4'h7, 1, 1, 0});

        // Reset in the middle of an LD wait must drop mem_read without a clock
        inst = 8'h0C;
        inst_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        n = 0;
        while (!mem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ld_wait mem_read_seen", int'(mem_read), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset mem_read", int'(mem_read), 0);
        check("async_reset inst_ready", int'(inst_ready), 1);
        check("async_reset busy", int'(busy), 0);
        check("async_reset retired", int'(retired), 0);
        check("async_reset bus_err", int'(bus_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("after_reset inst_ready", int'(inst_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
